// File: rtl/tmds_pkg.sv
// -----------------------------------------------------------------------------
// tmds_pkg
// Shared constants, types and helpers for the TMDS channel encoder.
//   DATA_W / SYM_W       : colour component width (8) and symbol width (10)
//   tmds_sym_t           : one 10-bit TMDS symbol, bit 0 transmitted first
//   TMDS_CTRL_xx         : control-period symbols selected by {c1, c0}
//   ctrl_symbol()        : maps {c1, c0} to its control symbol
//   count_ones()         : population count of an 8-bit word
// -----------------------------------------------------------------------------
package tmds_pkg;

    localparam int DATA_W = 8;
    localparam int SYM_W  = 10;

    typedef logic [SYM_W-1:0] tmds_sym_t;

    localparam tmds_sym_t TMDS_CTRL_00 = 10'b1101010100;
    localparam tmds_sym_t TMDS_CTRL_01 = 10'b0010101011;
    localparam tmds_sym_t TMDS_CTRL_10 = 10'b0101010100;
    localparam tmds_sym_t TMDS_CTRL_11 = 10'b1010101011;

    function automatic tmds_sym_t ctrl_symbol(input logic [1:0] ctrl);
        tmds_sym_t sym;
        case (ctrl)
            2'b00:   sym = TMDS_CTRL_00;
            2'b01:   sym = TMDS_CTRL_01;
            2'b10:   sym = TMDS_CTRL_10;
            default: sym = TMDS_CTRL_11;
        endcase
        return sym;
    endfunction

    function automatic logic [3:0] count_ones(input logic [DATA_W-1:0] d);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < DATA_W; i++) begin
            n = n + {3'b000, d[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tmds_qm_gen.sv
// -----------------------------------------------------------------------------
// tmds_qm_gen
// Transition-minimising first stage of TMDS encoding (purely combinational).
//   data [7:0] in  : colour component
//   q_m  [8:0] out : XOR/XNOR-chained word; q_m[8]=1 marks the XOR variant
// -----------------------------------------------------------------------------
module tmds_qm_gen
    import tmds_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W:0]   q_m
);

    logic [3:0] ones;
    logic       use_xnor;

    // NOTE: every signal written here gets a value before any branch or loop
    // touches it, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        ones     = count_ones(data);
        // XNOR chain when the input is ones-heavy keeps transitions low.
        use_xnor = (ones > 4'd4) || ((ones == 4'd4) && !data[0]);
        q_m      = '0;
        q_m[0]   = data[0];
        for (int i = 1; i < DATA_W; i++) begin
            q_m[i] = use_xnor ? ~(q_m[i-1] ^ data[i]) : (q_m[i-1] ^ data[i]);
        end
        q_m[DATA_W] = ~use_xnor;
    end

endmodule

// File: rtl/tmds_channel_encoder.sv
// -----------------------------------------------------------------------------
// tmds_channel_encoder
// One DVI/TMDS channel: 8-bit colour + 2 control bits -> DC-balanced 10-bit
// symbol, two-stage pipeline advanced only on the pixel strobe.
//   clk        in   system clock
//   n_rst      in   asynchronous active-low reset
//   pix_en     in   one-cycle pixel strobe; all state holds while low
//   de         in   1 = active video, 0 = control period
//   data [7:0] in   colour component
//   c0, c1     in   control bits used while de = 0
//   tmds_out   out  encoded symbol (bit 0 first), valid one strobe later
//   tmds_valid out  set after the second strobe since reset
// -----------------------------------------------------------------------------
module tmds_channel_encoder
    import tmds_pkg::*;
(
    input  logic              clk,
    input  logic              n_rst,
    input  logic              pix_en,
    input  logic              de,
    input  logic [DATA_W-1:0] data,
    input  logic              c0,
    input  logic              c1,
    output tmds_sym_t         tmds_out,
    output logic              tmds_valid
);

    logic [DATA_W:0] q_m_in;

    tmds_qm_gen u_qm_gen (
        .data (data),
        .q_m  (q_m_in)
    );

    // Stage 1 registers
    logic            s1_de;
    logic [1:0]      s1_ctrl;
    logic [DATA_W:0] s1_q_m;

    // Stage 2 state: running disparity (ones minus zeros of sent symbols)
    logic signed [4:0] cnt;
    logic              seen_strobe;

    // Stage 2 next-state logic
    logic [3:0]        n1;
    logic [3:0]        n0;
    logic signed [4:0] diff;      // n1 - n0 of q_m[7:0], range -8..+8
    logic              q8;
    logic signed [4:0] cnt_next;
    tmds_sym_t         sym_next;

    always_comb begin
        n1       = count_ones(s1_q_m[DATA_W-1:0]);
        n0       = 4'd8 - n1;
        diff     = $signed({1'b0, n1}) - $signed({1'b0, n0});
        q8       = s1_q_m[DATA_W];
        sym_next = ctrl_symbol(s1_ctrl);
        cnt_next = '0;

        if (s1_de) begin
            if ((cnt == 5'sd0) || (n1 == n0)) begin
                // Balanced word or balanced line: q_m[8] picks the inversion.
                sym_next = {~q8, q8, q8 ? s1_q_m[DATA_W-1:0] : ~s1_q_m[DATA_W-1:0]};
                cnt_next = q8 ? (cnt + diff) : (cnt - diff);
            end else if (((cnt > 5'sd0) && (n1 > n0)) || ((cnt < 5'sd0) && (n0 > n1))) begin
                // Word would push disparity further the same way: invert it.
                sym_next = {1'b1, q8, ~s1_q_m[DATA_W-1:0]};
                cnt_next = cnt + (q8 ? 5'sd2 : 5'sd0) - diff;
            end else begin
                sym_next = {1'b0, q8, s1_q_m[DATA_W-1:0]};
                cnt_next = cnt - (q8 ? 5'sd0 : 5'sd2) + diff;
            end
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1_de       <= 1'b0;
            s1_ctrl     <= 2'b00;
            s1_q_m      <= '0;
            cnt         <= '0;
            tmds_out    <= TMDS_CTRL_00;
            seen_strobe <= 1'b0;
            tmds_valid  <= 1'b0;
        end else if (pix_en) begin
            s1_de       <= de;
            s1_ctrl     <= {c1, c0};
            s1_q_m      <= q_m_in;
            cnt         <= cnt_next;
            tmds_out    <= sym_next;
            seen_strobe <= 1'b1;
            tmds_valid  <= seen_strobe;
        end
    end

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// -----------------------------------------------------------------------------
// tb_tmds_channel_encoder
// Self-checking bench: directed vector table, hold / reset sequences, and a
// randomized run compared against a behavioural model of the encoding rules.
// -----------------------------------------------------------------------------
module tb_tmds_channel_encoder;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       pix_en;
    logic       de;
    logic [7:0] data;
    logic       c0;
    logic       c1;
    logic [9:0] tmds_out;
    logic       tmds_valid;

    int checks   = 0;
    int failures = 0;

    tmds_channel_encoder dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .pix_en     (pix_en),
        .de         (de),
        .data       (data),
        .c0         (c0),
        .c1         (c1),
        .tmds_out   (tmds_out),
        .tmds_valid (tmds_valid)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit         m_de1;
    logic [1:0] m_ctrl1;
    logic [7:0] m_data1;
    logic [9:0] m_out;
    int         m_cnt;
    int         m_strobes;
    bit         m_valid;

    function automatic logic [9:0] ref_ctrl(input logic [1:0] c);
        logic [9:0] s;
        case (c)
            2'b00:   s = 10'b1101010100;
            2'b01:   s = 10'b0010101011;
            2'b10:   s = 10'b0101010100;
            default: s = 10'b1010101011;
        endcase
        return s;
    endfunction

    function automatic logic [8:0] ref_qm(input logic [7:0] d);
        int         ones;
        bit         use_xnor;
        logic [8:0] q;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        use_xnor = (ones > 4) || (ones == 4 && d[0] == 1'b0);
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = use_xnor ? 1'b0 : 1'b1;
        return q;
    endfunction

    task automatic model_reset();
        m_de1 = 0; m_ctrl1 = 2'b00; m_data1 = 8'h00;
        m_out = 10'b1101010100; m_cnt = 0; m_strobes = 0; m_valid = 0;
    endtask

    task automatic model_step(input bit d_e, input logic [7:0] d, input logic [1:0] c);
        logic [8:0] qm;
        int n1, n0, q8;
        if (!m_de1) begin
            m_out = ref_ctrl(m_ctrl1);
            m_cnt = 0;
        end else begin
            qm = ref_qm(m_data1);
            q8 = int'(qm[8]);
            n1 = 0;
            for (int i = 0; i < 8; i++) n1 += int'(qm[i]);
            n0 = 8 - n1;
            if (m_cnt == 0 || n1 == n0) begin
                m_out = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
                m_cnt = m_cnt + ((q8 == 1) ? (n1 - n0) : (n0 - n1));
            end else if ((m_cnt > 0 && n1 > n0) || (m_cnt < 0 && n0 > n1)) begin
                m_out = {1'b1, qm[8], ~qm[7:0]};
                m_cnt = m_cnt + 2 * q8 + (n0 - n1);
            end else begin
                m_out = {1'b0, qm[8], qm[7:0]};
                m_cnt = m_cnt - 2 * (1 - q8) + (n1 - n0);
            end
        end
        m_de1 = d_e; m_ctrl1 = c; m_data1 = d;
        m_strobes++;
        m_valid = (m_strobes >= 2);
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, "_out"},   int'(tmds_out),   int'(m_out));
        check({tag, "_valid"}, int'(tmds_valid), int'(m_valid));
        check({tag, "_cnt"},   int'(dut.cnt),    m_cnt);
    endtask

    // Called at a negedge: drive inputs, advance the model if strobing,
    // and return at the following negedge (one posedge later).
    task automatic drive_cycle(input bit en, input bit d_e, input logic [7:0] d,
                               input logic [1:0] c);
        pix_en = en; de = d_e; data = d; {c1, c0} = c;
        if (en) model_step(d_e, d, c);
        @(negedge clk);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         de;
        logic [7:0] data;
        logic [1:0] ctrl;
        logic [9:0] exp_out;   // symbol produced from this pixel
        int         exp_cnt;   // disparity after that symbol
    } vec_t;

    localparam int NVEC = 9;
    vec_t vecs[NVEC];

    initial begin
        int abs_cnt;
        int strobes;

        vecs[0] = '{0, 8'h00, 2'b00, 10'b1101010100,  0};
        vecs[1] = '{0, 8'h00, 2'b01, 10'b0010101011,  0};
        vecs[2] = '{0, 8'h00, 2'b11, 10'b1010101011,  0};
        vecs[3] = '{1, 8'h00, 2'b00, 10'b0100000000, -8};
        vecs[4] = '{1, 8'h00, 2'b00, 10'b1111111111,  2};
        vecs[5] = '{0, 8'h00, 2'b10, 10'b0101010100,  0};
        vecs[6] = '{1, 8'hFF, 2'b00, 10'b1000000000, -8};
        vecs[7] = '{0, 8'h00, 2'b00, 10'b1101010100,  0};
        vecs[8] = '{1, 8'h00, 2'b00, 10'b0100000000, -8};

        n_rst = 1'b0; pix_en = 1'b0; de = 1'b0; data = 8'h00; c0 = 1'b0; c1 = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_out",   int'(tmds_out),   int'(10'b1101010100));
        check("reset_valid", int'(tmds_valid), 0);
        check("reset_cnt",   int'(dut.cnt),    0);
        n_rst = 1'b1;
        @(negedge clk);

        // Table: row k's symbol appears after strobe k+1.
        for (int k = 0; k <= NVEC; k++) begin
            if (k < NVEC) drive_cycle(1, vecs[k].de, vecs[k].data, vecs[k].ctrl);
            else          drive_cycle(1, 0, 8'h00, 2'b00);
            if (k >= 1) begin
                check($sformatf("vec%0d_out", k - 1), int'(tmds_out), int'(vecs[k-1].exp_out));
                check($sformatf("vec%0d_cnt", k - 1), int'(dut.cnt),  vecs[k-1].exp_cnt);
            end
            check($sformatf("vec%0d_valid", k), int'(tmds_valid), (k >= 1) ? 1 : 0);
        end
        pix_en = 1'b0;

        // Active pixels, then strobe held low for 5 cycles: everything holds.
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1, 1, 8'($urandom), 2'b00);
            compare_model("pre_hold");
        end
        for (int i = 0; i < 5; i++) begin
            drive_cycle(0, 1, 8'($urandom), 2'($urandom));
            compare_model("hold");
        end

        // Asynchronous reset between edges, mid-run.
        pix_en = 1'b0;
        #2;
        n_rst = 1'b0;
        #1;
        check("async_rst_out",   int'(tmds_out),   int'(10'b1101010100));
        check("async_rst_valid", int'(tmds_valid), 0);
        check("async_rst_cnt",   int'(dut.cnt),    0);
        model_reset();
        @(negedge clk);
        n_rst = 1'b1;
        drive_cycle(1, 1, 8'h00, 2'b00);
        check("post_rst_first_out", int'(tmds_out), int'(10'b1101010100));
        drive_cycle(1, 0, 8'h00, 2'b10);
        check("post_rst_data_out", int'(tmds_out), int'(10'b0100000000));
        check("post_rst_data_cnt", int'(dut.cnt), -8);
        compare_model("post_rst");

        // Randomized run: bursts of back-to-back strobes and idle gaps.
        strobes = 0;
        while (strobes < 10000) begin
            bit en;
            en = ($urandom_range(0, 3) != 0);
            drive_cycle(en, ($urandom_range(0, 7) != 0), 8'($urandom), 2'($urandom));
            compare_model("rand");
            if (en) begin
                strobes++;
                abs_cnt = (int'(dut.cnt) < 0) ? -int'(dut.cnt) : int'(dut.cnt);
                check("rand_disparity_bound", int'(abs_cnt <= 8), 1);
            end
        end
        pix_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tmds_channel_encoder.md
# tmds_channel_encoder

One DVI/TMDS channel encoder. It converts one 8-bit colour component plus two control bits into a DC-balanced 10-bit TMDS symbol per pixel. It sits between the pixel-timing/pixel-data path (timers, frame buffer readout) and the 10:1 serializer that drives `p_tmdsN`/`n_tmdsN`. The top level instantiates three copies: blue with HSYNC/VSYNC on c0/c1, then green, then red.

## Interface
Parameters:
- none; symbol width fixed at 10, data width fixed at 8.

Ports:
- `clk`  in  1  system clock.
- `n_rst`  in  1  asynchronous, active-low reset.
- `pix_en`  in  1  pixel strobe, one `clk` cycle wide per pixel (from timer's `pixel_clk` edge); pipeline advances only on strobe.
- `de`  in  1  data enable; 1 = active video, 0 = blanking/control.
- `data`  in  8  colour component, sampled when `pix_en`=1.
- `c0`  in  1  control bit 0, used when `de`=0.
- `c1`  in  1  control bit 1, used when `de`=0.
- `tmds_out`  out  10  encoded symbol, bit 0 transmitted first.
- `tmds_valid`  out  1  high once two strobes have passed since reset; stays high.

Clock/reset: one clock `clk`; reset `n_rst` is asynchronous and active-low.

## Operation
- Stage 1 runs on a `pix_en` edge. It registers `de`, `c1:c0`, and the 9-bit transition-minimised word `q_m`:
  - N1(d) = number of ones in `data`.
  - If N1>4, or N1==4 and `data[0]`==0: `q_m[0]`=`d[0]`, `q_m[i]`=`q_m[i-1]` XNOR `d[i]`, `q_m[8]`=0.
  - Otherwise use XOR and set `q_m[8]`=1.
- Stage 2 runs on the next `pix_en` edge. It produces `tmds_out` and updates `cnt`, a signed 5-bit running disparity (ones minus zeros). N1/N0 below count ones/zeros of `q_m[7:0]`.
  - `de`=1, `cnt`==0 or N1==N0:
    - out = {~`q_m[8]`, `q_m[8]`, `q_m[8]` ? `q_m[7:0]` : ~`q_m[7:0]`}.
    - `cnt` += `q_m[8]` ? (N1−N0) : (N0−N1).
  - `de`=1, (`cnt`>0 and N1>N0) or (`cnt`<0 and N0>N1):
    - out = {1, `q_m[8]`, ~`q_m[7:0]`}.
    - `cnt` = `cnt` + 2·`q_m[8]` + (N0−N1).
  - `de`=1, else:
    - out = {0, `q_m[8]`, `q_m[7:0]`}.
    - `cnt` = `cnt` − 2·(~`q_m[8]`) + (N1−N0).
  - `de`=0: output the control symbol and set `cnt`=0.
    - c1c0=00 → 10'b1101010100.
    - 01 → 10'b0010101011.
    - 10 → 10'b0101010100.
    - 11 → 10'b1010101011.
- All arithmetic is signed 5-bit. `cnt` stays within −8..+8 by construction; no saturation logic.

## Timing
- Reset values: `tmds_out`=10'b1101010100 (control 00), `cnt`=0, stage-1 regs zero with `de`=0, `tmds_valid`=0.
- Latency: inputs sampled on strobe k appear on `tmds_out` after the `clk` edge of strobe k+1. The output holds until strobe k+2.
- `pix_en`=0: every register holds, including `cnt`.
- `tmds_valid` rises with the second strobe after reset and never falls until reset.
- `de` toggling between consecutive pixels: each symbol is encoded from its own `de`. The first active pixel after blanking starts from `cnt`=0.
- Reset asserted mid-line: immediate asynchronous return to reset values. The first symbol after release is encoded with `cnt`=0.
- Back-to-back strobes (`pix_en` held high) are legal. The encoder then runs at one symbol per `clk`.

## Structure
- `tmds_pkg`:
  - constants `TMDS_CTRL_00`, `TMDS_CTRL_01`, `TMDS_CTRL_10`, `TMDS_CTRL_11`.
  - localparams for data width (8) and symbol width (10).
  - typedef `tmds_sym_t` (logic [9:0]).
- Sub-module `tmds_qm_gen`: combinational ones-count plus XOR/XNOR chain producing `q_m[8:0]`. Instantiated before stage 1.
- Disparity counter and output selection stay in `tmds_channel_encoder`.

## Test plan
- Reset, then 3 strobes with `de`=0 and c1c0=00/01/11 → outputs 1101010100, 0010101011, 1010101011, each one strobe late; `tmds_valid` high from the 2nd strobe.
- `de`=1, `data`=8'h00 twice from `cnt`=0:
  - first output 10'b0100000000, `cnt`=−8.
  - second output 10'b1111111111, `cnt`=+2.
- `de`=1, `data`=8'hFF from `cnt`=0 → output 10'b1000000000, `cnt`=−8.
- Active run, then `de`=0 with c1c0=10 → output 0101010100 and `cnt`=0. The next `data`=8'h00 again yields 10'b0100000000.
- `pix_en` held low 5 cycles mid-run → `tmds_out` and `cnt` unchanged. Compare against a reference model over 10k random pixels: symbols must match and |running disparity| ≤ 8.
- Assert `n_rst` between strobes mid-run → `tmds_out`=1101010100 and `tmds_valid`=0 the same cycle, with no `clk` edge needed.
